calc_operand_entry: RTL

CALC_OPERAND_ENTRY -- requirements
Module: calc_operand_entry

---
 rtl/calc_pkg.sv | 27 ++
 rtl/calc_operand_entry_if.sv | 25 ++
 rtl/calc_digit_acc.sv | 56 +++++
 rtl/calc_operand_entry.sv | 120 ++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, entry FSM states and operand width for the calculator front end.
package calc_pkg;

    localparam int unsigned OPND_W = 7;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [3:0] KEY_ADD       = 4'd10;
    localparam logic [3:0] KEY_SUB       = 4'd11;
    localparam logic [3:0] KEY_MUL       = 4'd12;
    localparam logic [3:0] KEY_CLR       = 4'd13;
    localparam logic [3:0] KEY_EQ        = 4'd14;

    typedef enum logic [1:0] {
        S_OP1    = 2'd0,
        S_OP2    = 2'd1,
        S_RESULT = 2'd2
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= KEY_DIGIT_MAX;
    endfunction

    function automatic logic is_op(input logic [3:0] k);
        return (k >= KEY_ADD) && (k <= KEY_MUL);
    endfunction

endpackage

// File: rtl/calc_operand_entry_if.sv
// Key input and operand/operator output bundle between keypad logic and calculator stage.
interface calc_operand_entry_if;
    import calc_pkg::*;

    logic              modo;
    logic              key_valid;
    logic [3:0]        key_code;
    logic [OPND_W-1:0] In1;
    logic [OPND_W-1:0] In2;
    logic [3:0]        keyboard;
    logic              result_valid;
    logic [1:0]        entry_state;
    logic [1:0]        digit_count;

    modport master (
        output modo, key_valid, key_code,
        input  In1, In2, keyboard, result_valid, entry_state, digit_count
    );

    modport slave (
        input  modo, key_valid, key_code,
        output In1, In2, keyboard, result_valid, entry_state, digit_count
    );

endinterface

// File: rtl/calc_digit_acc.sv
// Decimal operand accumulator: shifts in digits up to MAX_DIGITS, then saturates.
module calc_digit_acc
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              digit_en_i,
    input  logic [3:0]        digit_i,
    output logic [OPND_W-1:0] val_o,
    output logic [1:0]        cnt_o
);

    localparam logic [1:0]        CNT_MAX = 2'(MAX_DIGITS);
    localparam logic [OPND_W-1:0] TEN     = OPND_W'(10);

    logic [OPND_W-1:0] val_q, val_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [OPND_W-1:0] digit_ext;

    assign digit_ext = {{(OPND_W-4){1'b0}}, digit_i};

    // Next value: clear beats load beats digit shift; a full operand ignores digits.
    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            val_d = '0;
            cnt_d = '0;
        end else if (load_i) begin
            val_d = digit_ext;
            cnt_d = 2'd1;
        end else if (digit_en_i && (cnt_q != CNT_MAX)) begin
            val_d = val_q * TEN + digit_ext;
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Operand and digit-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            cnt_q <= '0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign val_o = val_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/calc_operand_entry.sv
// Keypad operand entry FSM: builds two operands and an operator, launches on equals.
module calc_operand_entry
    import calc_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    calc_operand_entry_if.slave bus
);

    entry_state_t state_q, state_d;
    logic [3:0]   op_q, op_d;
    logic [3:0]   kb_q, kb_d;
    logic         rv_q, rv_d;

    logic              accepted;
    logic              clr1, clr2, load1, dig1, dig2;
    logic [OPND_W-1:0] val1, val2;
    logic [1:0]        cnt1, cnt2;

    assign accepted = bus.modo && bus.key_valid;

    // Next-state, operator latch, output strobes and accumulator controls.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        kb_d    = (state_q == S_RESULT) ? kb_q : '0;
        rv_d    = 1'b0;
        clr1    = 1'b0;
        clr2    = 1'b0;
        load1   = 1'b0;
        dig1    = 1'b0;
        dig2    = 1'b0;
        if (accepted && (bus.key_code == KEY_CLR)) begin
            state_d = S_OP1;
            op_d    = '0;
            kb_d    = KEY_CLR;
            clr1    = 1'b1;
            clr2    = 1'b1;
        end else begin
            case (state_q)
                S_OP1: begin
                    if (accepted && is_digit(bus.key_code)) begin
                        dig1 = 1'b1;
                    end else if (accepted && is_op(bus.key_code)) begin
                        op_d    = bus.key_code;
                        state_d = S_OP2;
                    end
                end
                S_OP2: begin
                    if (accepted && is_digit(bus.key_code)) begin
                        dig2 = 1'b1;
                    end else if (accepted && is_op(bus.key_code) && (cnt2 == '0)) begin
                        op_d = bus.key_code;
                    end else if (accepted && (bus.key_code == KEY_EQ) && (cnt2 != '0)) begin
                        state_d = S_RESULT;
                        kb_d    = op_q;
                        rv_d    = 1'b1;
                    end
                end
                S_RESULT: begin
                    if (accepted && is_digit(bus.key_code)) begin
                        load1   = 1'b1;
                        clr2    = 1'b1;
                        kb_d    = '0;
                        state_d = S_OP1;
                    end
                end
                default: state_d = S_OP1;
            endcase
        end
    end

    // FSM state, latched operator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OP1;
            op_q    <= '0;
            kb_q    <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            kb_q    <= kb_d;
            rv_q    <= rv_d;
        end
    end

    calc_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr1),
        .load_i     (load1),
        .digit_en_i (dig1),
        .digit_i    (bus.key_code),
        .val_o      (val1),
        .cnt_o      (cnt1)
    );

    calc_digit_acc #(.MAX_DIGITS(MAX_DIGITS)) u_acc2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr2),
        .load_i     (1'b0),
        .digit_en_i (dig2),
        .digit_i    (bus.key_code),
        .val_o      (val2),
        .cnt_o      (cnt2)
    );

    // Operand 2 is always empty while in S_OP1, so the active count is selected by state.
    assign bus.In1          = val1;
    assign bus.In2          = val2;
    assign bus.keyboard     = kb_q;
    assign bus.result_valid = rv_q;
    assign bus.entry_state  = state_q;
    assign bus.digit_count  = (state_q == S_OP1) ? cnt1 : cnt2;

endmodule
